seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Memory-mapped eight-digit seven-segment display controller on the MiniMIPS32 SoC I/O bus. It is the output-side counterpart of the 8-bit switch input port. The CPU writes a 32-bit hex value plus control masks; the block time-multiplexes the eight digits onto shared active-low anode/cathode pins. Registers are readable back over the same bus.

## Interface
- SCAN_DIV, 16'd50000, clock cycles each digit is driven (minimum 2)
- BLINK_DIV, 26'd25000000, clock cycles per blink phase (only used with SEG7_BLINK_EN)
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- io_ce  in  1  bus select for this block
- io_we  in  1  1 = write, 0 = read (qualified by io_ce)
- io_addr  in  2  word offset: 0 DATA, 1 EN, 2 DP, 3 BLINK
- io_wdata  in  32  write data
- io_rdata  out  32  registered read data
- seg_an  out  8  digit anodes, active-low, bit i = digit i
- seg_cat  out  8  cathodes {dp,g,f,e,d,c,b,a}, active-low

## Operation
- Registers: DATA[31:0] (digit i = DATA[4i+3:4i]); EN[7:0] (digit enable); DP[7:0] (decimal point on); BLINK[7:0].
- Write: io_ce&&io_we at posedge updates addressed register; unused upper bits of EN/DP/BLINK ignored.
- Read: io_ce&&!io_we latches addressed register (zero-extended) into io_rdata; otherwise io_rdata holds its value.
- Scan: cycle counter cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and digit index idx increments mod 8 (7 -> 0).
- Output registers update every cycle from current idx and registers: seg_an = ~((8'b1<<idx) & EN & ~blank); seg_cat = {~DP[idx], hexseg(nibble idx)}.
- hexseg (active-low, bits 7..0 with dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Disabled or blanked digit: its anode stays 1; seg_cat still driven with decoded value.
- Reset values: DATA 0, EN 8'hFF, DP 0, BLINK 0, cnt 0, idx 0, blink phase 0, io_rdata 0, seg_an 8'hFF, seg_cat 8'hFF.

## Timing
- Register write visible on pins 2 cycles after the write edge (register, then output register).
- Read latency 1 cycle: io_rdata valid the cycle after the io_ce&&!io_we edge.
- Digit period = SCAN_DIV cycles; full frame = 8*SCAN_DIV cycles; seg_an and seg_cat always change on the same edge.
- Write coinciding with idx advance: both take effect; new digit shows new data.
- Read and write to the same register are exclusive (single io_we); read returns pre-write value only if issued before the write.
- Reset mid-scan: next cycle all state at reset values; scan restarts at digit 0, cnt 0.

## Configuration
- SEG7_BLINK_EN defined: BLINK register implemented; free-running counter toggles blink phase every BLINK_DIV cycles; blank = BLINK[idx] & phase; counter reset to 0 by rst.
- SEG7_BLINK_EN undefined: no blink counter; blank = 0; writes to offset 3 ignored; reads of offset 3 return 0.

## Test plan
- Reset, SCAN_DIV=4: seg_an=FF, seg_cat=FF in cycle after reset; then seg_an=FE, seg_cat=C0 for 4 cycles, then FD, and 7F before wrapping to FE.
- Write DATA=32'h76543210, read offset 0 -> io_rdata=76543210 one cycle later; digit 0 cat C0, digit 3 B0, digit 7 F8.
- Write DATA=32'hFEDCBA98, DP=8'h01: digit 0 cat=00 (8 with dp), digit 7 cat=8E.
- Write EN=8'h0F: anodes for digits 4..7 never go low over a full frame; read offset 1 -> 0000000F.
- Assert rst mid-digit 5: next cycle seg_an=FF, io_rdata=0; scan resumes at digit 0; DATA reads 0.
- SEG7_BLINK_EN, BLINK_DIV=16, BLINK=8'h01: digit 0 anode low only while phase=0; without macro read offset 3 -> 0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: bus-mapped eight-digit seven-segment scan controller.
// Registers DATA/EN/DP/BLINK at word offsets 0..3; digits are time-multiplexed
// onto shared active-low anode/cathode pins, SCAN_DIV cycles per digit.
// Optional blink support is compiled in with SEG7_BLINK_EN.
module seg7_scan_ctrl #(
  parameter logic [15:0] SCAN_DIV  = 16'd50000,
  parameter logic [25:0] BLINK_DIV = 26'd25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_ce,
  input  logic        io_we,
  input  logic [1:0]  io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  logic [31:0] data;
  logic [7:0]  en;
  logic [7:0]  dp;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic        blank;
  logic [31:0] rd_blink;
  logic [31:0] rd_mux;
  logic [3:0]  nibble;
  logic [6:0]  hex;
  logic [7:0]  an_next;
  logic [7:0]  cat_next;

  // Bus writes to the always-present registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      en   <= '1;
      dp   <= '0;
    end else if (io_ce && io_we) begin
      case (io_addr)
        2'd0:    data <= io_wdata;
        2'd1:    en   <= io_wdata[7:0];
        2'd2:    dp   <= io_wdata[7:0];
        default: ;
      endcase
    end
  end

`ifdef SEG7_BLINK_EN
  logic [7:0]  blink;
  logic [25:0] bcnt;
  logic        phase;

  // BLINK register write.
  always_ff @(posedge clk) begin
    if (rst)
      blink <= '0;
    else if (io_ce && io_we && io_addr == 2'd3)
      blink <= io_wdata[7:0];
  end

  // Free-running blink timer; phase flips every BLINK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BLINK_DIV - 26'd1) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 26'd1;
    end
  end

  assign blank    = blink[idx] & phase;
  assign rd_blink = {24'b0, blink};
`else
  logic unused_blink_div;

  assign unused_blink_div = ^BLINK_DIV;
  assign blank            = 1'b0;
  assign rd_blink         = '0;
`endif

  // Digit scan: cnt walks 0..SCAN_DIV-1, idx advances on each wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == SCAN_DIV - 16'd1) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Read-back mux, registers zero-extended.
  always_comb begin
    rd_mux = '0;
    case (io_addr)
      2'd0:    rd_mux = data;
      2'd1:    rd_mux = {24'b0, en};
      2'd2:    rd_mux = {24'b0, dp};
      default: rd_mux = rd_blink;
    endcase
  end

  // Registered read data; holds when not reading.
  always_ff @(posedge clk) begin
    if (rst)
      io_rdata <= '0;
    else if (io_ce && !io_we)
      io_rdata <= rd_mux;
  end

  // Hex-to-segment decode for the current digit, active-low {g..a}.
  always_comb begin
    nibble = data[{idx, 2'b00} +: 4];
    hex    = 7'h7F;
    case (nibble)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
      default: hex = 7'h7F;
    endcase
    // blank is a scalar, so replicate it before inverting against the 8-bit mask
    an_next  = ~((8'b1 << idx) & en & {8{~blank}});
    cat_next = {~dp[idx], hex};
  end

  // Pin output registers; anodes and cathodes change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_an  <= '1;
      seg_cat <= '1;
    end else begin
      seg_an  <= an_next;
      seg_cat <= cat_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=4, BLINK_DIV=16.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_ce;
  logic        io_we;
  logic [1:0]  io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;

  int total = 0;
  int bad   = 0;
  int pos   = 0;   // clock edges since reset was released

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .SCAN_DIV (16'd4),
    .BLINK_DIV(26'd16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io_ce   (io_ce),
    .io_we   (io_we),
    .io_addr (io_addr),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .seg_an  (seg_an),
    .seg_cat (seg_cat)
  );

  task automatic step();
    @(posedge clk);
    #1;
    pos++;
  endtask

  // Digit shown on the pins after edge number pos (4 edges per digit).
  function automatic int disp();
    return ((pos - 1) / 4) % 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    io_ce = 1'b1; io_we = 1'b1; io_addr = a; io_wdata = d;
    step();
    io_ce = 1'b0; io_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    io_ce = 1'b1; io_we = 1'b0; io_addr = a;
    step();
    io_ce = 1'b0;
  endtask

  task automatic wait_digit(input int d);
    int n = 0;
    while (disp() != d && n < 40) begin
      step();
      n++;
    end
    chk("wait_digit", disp(), d);
  endtask

  initial begin
    logic [7:0] exp_an;
    bit         exp_hi;
    rst = 1'b1; io_ce = 1'b0; io_we = 1'b0; io_addr = '0; io_wdata = '0;
    step();
    step();
    chk("rst_an", seg_an, 8'hFF);
    chk("rst_cat", seg_cat, 8'hFF);
    chk("rst_rdata", io_rdata, 32'h0);

    // Scan order after reset
    rst = 1'b0;
    pos = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("d0_an", seg_an, 8'hFE);
      chk("d0_cat", seg_cat, 8'hC0);
    end
    step();
    chk("d1_an", seg_an, 8'hFD);
    for (int d = 2; d < 8; d++) begin
      wait_digit(d);
      exp_an = ~(8'b1 << d);
      chk("scan_an", seg_an, exp_an);
    end
    wait_digit(0);
    chk("wrap_an", seg_an, 8'hFE);

    // Blink register and blanking on digit 0
    wr(2'd3, 32'h0000_0001);
    rd(2'd3);
`ifdef SEG7_BLINK_EN
    chk("rd_blink", io_rdata, 32'h1);
`else
    chk("rd_blink", io_rdata, 32'h0);
`endif
    step();
    for (int i = 0; i < 64; i++) begin
      step();
`ifdef SEG7_BLINK_EN
      exp_hi = !(disp() == 0 && ((pos - 1) / 16) % 2 == 0);
`else
      exp_hi = !(disp() == 0);
`endif
      chk("blink_an0", {31'b0, seg_an[0]}, {31'b0, exp_hi});
    end
    wr(2'd3, 32'h0);
    step();
    step();

    // DATA write and read-back
    wr(2'd0, 32'h7654_3210);
    rd(2'd0);
    chk("rd_data", io_rdata, 32'h7654_3210);
    step();
    wait_digit(0);
    chk("d0_cat_a", seg_cat, 8'hC0);
    chk("d0_an_a", seg_an, 8'hFE);
    wait_digit(3);
    chk("d3_cat", seg_cat, 8'hB0);
    chk("d3_an", seg_an, 8'hF7);
    wait_digit(7);
    chk("d7_cat", seg_cat, 8'hF8);
    chk("d7_an", seg_an, 8'h7F);

    // Decimal point
    wr(2'd0, 32'hFEDC_BA98);
    wr(2'd2, 32'h0000_0001);
    step();
    wait_digit(0);
    chk("d0_cat_dp", seg_cat, 8'h00);
    wait_digit(1);
    chk("d1_cat_9", seg_cat, 8'h90);
    wait_digit(7);
    chk("d7_cat_F", seg_cat, 8'h8E);
    rd(2'd2);
    chk("rd_dp", io_rdata, 32'h1);

    // Digit enable mask: upper four digits stay dark
    wr(2'd1, 32'hFFFF_FF0F);
    step();
    step();
    for (int i = 0; i < 32; i++) begin
      step();
      chk("en_hi_dark", {28'b0, seg_an[7:4]}, 32'hF);
    end
    wait_digit(2);
    chk("en_d2_an", seg_an, 8'hFB);
    rd(2'd1);
    chk("rd_en", io_rdata, 32'h0000_000F);

    // Reset in the middle of digit 5
    wr(2'd1, 32'hFF);
    wait_digit(5);
    step();
    rst = 1'b1;
    step();
    chk("mrst_an", seg_an, 8'hFF);
    chk("mrst_cat", seg_cat, 8'hFF);
    chk("mrst_rdata", io_rdata, 32'h0);
    rst = 1'b0;
    pos = 0;
    step();
    chk("mrst_d0_an", seg_an, 8'hFE);
    chk("mrst_d0_cat", seg_cat, 8'hC0);
    rd(2'd0);
    chk("mrst_rd_data", io_rdata, 32'h0);
    rd(2'd1);
    chk("mrst_rd_en", io_rdata, 32'hFF);
    wait_digit(1);
    chk("mrst_d1_an", seg_an, 8'hFD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
